// File: rtl/uart_pkt_parser.sv
// Packet framer behind the UART receiver: [SOF][CMD][LEN][PAYLOAD x LEN][CHK].
// Streams payload bytes, flags each packet ok/err, aborts on inter-byte silence.
module uart_pkt_parser #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] SOF         = 'hAA,
   parameter int                    MAX_LEN     = 64,
   parameter int                    TIMEOUT_CYC = 100_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_done,
   output logic [DATA_WIDTH-1:0] pl_data,
   output logic                  pl_valid,
   output logic [7:0]            pl_idx,
   output logic [DATA_WIDTH-1:0] pkt_cmd,
   output logic [7:0]            pkt_len,
   output logic                  pkt_ok,
   output logic                  pkt_err,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

   localparam logic [1:0] E_CHK = 2'b01;
   localparam logic [1:0] E_LEN = 2'b10;
   localparam logic [1:0] E_TO  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAY,
      S_CHK
   } state_t;

   state_t                r_state;
   state_t                w_state_n;

   logic [DATA_WIDTH-1:0] r_sum;
   logic [DATA_WIDTH-1:0] w_sum_n;
   logic [7:0]            r_idx;
   logic [7:0]            w_idx_n;
   logic [TW-1:0]         r_tcnt;
   logic [TW-1:0]         w_tcnt_n;

   logic [DATA_WIDTH-1:0] r_pl_data;
   logic [DATA_WIDTH-1:0] w_pl_data_n;
   logic                  r_pl_valid;
   logic                  w_pl_valid_n;
   logic [7:0]            r_pl_idx;
   logic [7:0]            w_pl_idx_n;
   logic [DATA_WIDTH-1:0] r_cmd;
   logic [DATA_WIDTH-1:0] w_cmd_n;
   logic [7:0]            r_len;
   logic [7:0]            w_len_n;
   logic                  r_ok;
   logic                  w_ok_n;
   logic                  r_err;
   logic                  w_err_n;
   logic [1:0]            r_code;
   logic [1:0]            w_code_n;

   logic [7:0]            w_byte8;
   logic                  w_last;

   assign w_byte8 = 8'(rx_data);
   assign w_last  = (r_idx == (r_len - 8'd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sum      <= '0;
         r_idx      <= '0;
         r_tcnt     <= '0;
         r_pl_data  <= '0;
         r_pl_valid <= 1'b0;
         r_pl_idx   <= '0;
         r_cmd      <= '0;
         r_len      <= '0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_code     <= '0;
      end else begin
         r_state    <= w_state_n;
         r_sum      <= w_sum_n;
         r_idx      <= w_idx_n;
         r_tcnt     <= w_tcnt_n;
         r_pl_data  <= w_pl_data_n;
         r_pl_valid <= w_pl_valid_n;
         r_pl_idx   <= w_pl_idx_n;
         r_cmd      <= w_cmd_n;
         r_len      <= w_len_n;
         r_ok       <= w_ok_n;
         r_err      <= w_err_n;
         r_code     <= w_code_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_sum_n      = r_sum;
      w_idx_n      = r_idx;
      w_tcnt_n     = r_tcnt;
      w_pl_data_n  = r_pl_data;
      w_pl_valid_n = 1'b0;
      w_pl_idx_n   = r_pl_idx;
      w_cmd_n      = r_cmd;
      w_len_n      = r_len;
      w_ok_n       = 1'b0;
      w_err_n      = 1'b0;
      w_code_n     = r_code;

      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (rx_done) begin
         w_tcnt_n = '0;
         unique case (r_state)
            S_IDLE: begin
               if (rx_data == SOF) begin
                  w_state_n = S_CMD;
               end
            end
            S_CMD: begin
               w_cmd_n   = rx_data;
               w_sum_n   = rx_data;
               w_state_n = S_LEN;
            end
            S_LEN: begin
               w_len_n = w_byte8;
               w_sum_n = r_sum + rx_data;
               w_idx_n = '0;
               if (w_byte8 > LEN_MAX) begin
                  w_err_n   = 1'b1;
                  w_code_n  = E_LEN;
                  w_state_n = S_IDLE;
               end else if (w_byte8 == 8'd0) begin
                  w_state_n = S_CHK;
               end else begin
                  w_state_n = S_PAY;
               end
            end
            S_PAY: begin
               w_pl_valid_n = 1'b1;
               w_pl_data_n  = rx_data;
               w_pl_idx_n   = r_idx;
               w_sum_n      = r_sum + rx_data;
               if (w_last) begin
                  w_state_n = S_CHK;
               end else begin
                  w_idx_n = r_idx + 8'd1;
               end
            end
            S_CHK: begin
               if (rx_data == r_sum) begin
                  w_ok_n = 1'b1;
               end else begin
                  w_err_n  = 1'b1;
                  w_code_n = E_CHK;
               end
               w_state_n = S_IDLE;
            end
            default: begin
               w_state_n = S_IDLE;
            end
         endcase
      end else if (r_state != S_IDLE) begin
         if (r_tcnt == TO_LAST) begin
            w_err_n   = 1'b1;
            w_code_n  = E_TO;
            w_state_n = S_IDLE;
         end else begin
            w_tcnt_n = r_tcnt + 1'b1;
         end
      end

      if (w_state_n == S_IDLE) begin
         w_tcnt_n = '0;
      end
   end

   assign pl_data  = r_pl_data;
   assign pl_valid = r_pl_valid;
   assign pl_idx   = r_pl_idx;
   assign pkt_cmd  = r_cmd;
   assign pkt_len  = r_len;
   assign pkt_ok   = r_ok;
   assign pkt_err  = r_err;
   assign err_code = r_code;
   assign busy     = (r_state != S_IDLE);

endmodule
